// File: rtl/fetch_seq.sv
// fetch_seq: MIPS instruction-fetch sequencer. Owns the architectural PC, fetches over req/ack, delivers over valid/ready.
// Define FETCH_DELAY_SLOT_EN to defer redirects until the branch delay-slot instruction has transferred.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redir_valid,
  input  logic [1:0]  redir_op,
  input  logic [31:0] redir_pc,
  input  logic [25:0] redir_imm,
  input  logic [31:0] redir_ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);

  typedef enum logic {S_FETCH, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        redir_hit;
  logic        xfer;
  logic [31:0] target;
  logic [31:0] next_seq;
`ifdef FETCH_DELAY_SLOT_EN
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] slot_q, slot_d;
  logic [31:0] slot_pc;
`else
  logic        kill_q, kill_d;
`endif

  always_comb begin
    case (redir_op)
      2'b01:   target = redir_pc + 32'd4 + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
      2'b10:   target = {redir_pc[31:28], redir_imm, 2'b00};
      2'b11:   target = redir_ra;
      default: target = pc_q;
    endcase
  end

`ifdef FETCH_DELAY_SLOT_EN
  // A redirect arriving while one is already pending is dropped.
  assign slot_pc   = redir_pc + 32'd4;
  assign redir_hit = redir_valid & (redir_op != 2'b00) & ~pend_q;
  assign xfer      = valid_q & if_ready;
  assign if_valid  = valid_q;
`else
  // The buffered instruction is hidden from decode in the redirect cycle.
  assign redir_hit = redir_valid & (redir_op != 2'b00);
  assign xfer      = valid_q & if_ready & ~redir_hit;
  assign if_valid  = valid_q & ~redir_hit;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    valid_d    = valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    next_seq   = if_pc_q + 32'd4;
`ifdef FETCH_DELAY_SLOT_EN
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    slot_d     = slot_q;

    if (redir_hit && !(xfer && (if_pc_q == slot_pc))) begin
      pend_d     = 1'b1;
      pend_tgt_d = target;
      slot_d     = slot_pc;
    end

    if (pend_q && (if_pc_q == slot_q)) begin
      next_seq = pend_tgt_q;
    end else if (redir_hit && (if_pc_q == slot_pc)) begin
      next_seq = target;
    end

    case (state_q)
      S_FETCH: begin
        req_d = 1'b1;
        if (imem_ack && req_q) begin
          if_pc_d    = pc_q;
          if_instr_d = imem_rdata;
          valid_d    = 1'b1;
          req_d      = 1'b0;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (xfer) begin
          pc_d    = next_seq;
          addr_d  = next_seq;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
          if (pend_q && (if_pc_q == slot_q)) begin
            pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
`else
    kill_d = kill_q;

    case (state_q)
      S_FETCH: begin
        req_d = 1'b1;
        if (redir_hit) begin
          pc_d = target;
          // An outstanding request keeps its address until acked; its data is discarded.
          if (req_q && imem_ack) begin
            addr_d = target;
            kill_d = 1'b0;
          end else if (req_q) begin
            kill_d = 1'b1;
          end else begin
            addr_d = target;
          end
        end else if (imem_ack && req_q) begin
          if (kill_q) begin
            kill_d = 1'b0;
            addr_d = pc_q;
          end else begin
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
            valid_d    = 1'b1;
            req_d      = 1'b0;
            state_d    = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redir_hit) begin
          pc_d    = target;
          addr_d  = target;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end else if (xfer) begin
          pc_d    = next_seq;
          addr_d  = next_seq;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= '0;
`ifdef FETCH_DELAY_SLOT_EN
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      slot_q     <= '0;
`else
      kill_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
`ifdef FETCH_DELAY_SLOT_EN
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      slot_q     <= slot_d;
`else
      kill_q     <= kill_d;
`endif
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed and randomized checks of fetch_seq against a transaction-level fetch-stream model.
module tb_fetch_seq;

  localparam logic [31:0] RST = 32'h0000_3000;

  logic        clk;
  logic        rst_n;
  logic        redir_valid;
  logic [1:0]  redir_op;
  logic [31:0] redir_pc;
  logic [25:0] redir_imm;
  logic [31:0] redir_ra;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  int n_vec = 0;
  int n_err = 0;

  // Model: m_next is the PC of the next instruction decode should see.
  bit          m_started, m_have, m_stale, m_pend, m_redir;
  logic [31:0] m_next, m_stale_addr, m_pend_tgt, m_slot;
  bit          exp_req, exp_valid;
  logic [31:0] exp_addr, exp_pc, exp_instr;

  fetch_seq #(.RESET_PC(RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .redir_valid(redir_valid), .redir_op(redir_op), .redir_pc(redir_pc),
    .redir_imm(redir_imm), .redir_ra(redir_ra),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] calc_target(input logic [1:0] op, input logic [31:0] pc,
                                              input logic [25:0] imm, input logic [31:0] ra);
    int off;
    off = int'($signed(imm[15:0])) * 4;
    case (op)
      2'b01:   return pc + 32'd4 + 32'(off);
      2'b10:   return (pc & 32'hF000_0000) + (32'(imm) * 32'd4);
      default: return ra;
    endcase
  endfunction

  task automatic model_reset();
    m_started = 0; m_have = 0; m_stale = 0; m_pend = 0;
    m_next = RST; m_stale_addr = RST; m_pend_tgt = '0; m_slot = '0;
  endtask

  // Drive memory data for the current address and form this cycle's expectations.
  task automatic settle();
    #1;
    imem_rdata = mem_word(imem_addr);
    m_redir = redir_valid && (redir_op != 2'b00);
`ifdef FETCH_DELAY_SLOT_EN
    m_redir = m_redir && !m_pend;
    exp_valid = m_have;
`else
    exp_valid = m_have && !m_redir;
`endif
    exp_req   = m_started && !m_have;
    exp_addr  = m_stale ? m_stale_addr : m_next;
    exp_pc    = m_next;
    exp_instr = mem_word(m_next);
  endtask

  task automatic model_advance();
    bit xfer, acked;
    logic [31:0] tgt;
    xfer  = exp_valid && if_ready;
    acked = exp_req && imem_ack;
    tgt   = calc_target(redir_op, redir_pc, redir_imm, redir_ra);
`ifdef FETCH_DELAY_SLOT_EN
    if (m_redir && !(xfer && m_next == redir_pc + 32'd4)) begin
      m_pend = 1; m_pend_tgt = tgt; m_slot = redir_pc + 32'd4;
    end
    if (acked) m_have = 1;
    if (xfer) begin
      m_have = 0;
      if (m_redir && m_next == redir_pc + 32'd4) m_next = tgt;
      else if (m_pend && m_next == m_slot) begin m_next = m_pend_tgt; m_pend = 0; end
      else m_next = m_next + 32'd4;
    end
`else
    if (m_redir) begin
      if (acked) m_stale = 0;
      else if (exp_req && !m_stale) begin m_stale = 1; m_stale_addr = m_next; end
      m_have = 0;
      m_next = tgt;
    end else begin
      if (acked) begin
        if (m_stale) m_stale = 0;
        else m_have = 1;
      end
      if (xfer) begin m_have = 0; m_next = m_next + 32'd4; end
    end
`endif
    m_started = 1;
  endtask

  task automatic tick();
    model_advance();
    @(negedge clk);
  endtask

  task automatic clear_redir();
    redir_valid = 0; redir_op = 2'b00; redir_pc = '0; redir_imm = '0; redir_ra = '0;
  endtask

  task automatic do_reset();
    rst_n = 0; clear_redir(); imem_ack = 0; if_ready = 0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1;
  endtask

  task automatic run_until_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (exp_valid) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 0; clear_redir(); imem_ack = 1; if_ready = 1;
    @(negedge clk); #1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_vec++; if (imem_addr !== RST) begin n_err++; $display("FAIL rst_addr got %h exp %h", imem_addr, RST); end
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", if_valid); end
    n_vec++; if (if_pc !== RST) begin n_err++; $display("FAIL rst_pc got %h exp %h", if_pc, RST); end
    n_vec++; if (if_instr !== 32'd0) begin n_err++; $display("FAIL rst_instr got %h exp 0", if_instr); end
    model_reset();
    rst_n = 1; imem_ack = 0;
    settle();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req_pre got %b exp 0", imem_req); end
    tick(); settle();
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rst_req_rise got %b exp 1", imem_req); end
    n_vec++; if (imem_addr !== RST) begin n_err++; $display("FAIL rst_first_addr got %h exp %h", imem_addr, RST); end
  endtask

  task automatic test_sequential();
    logic [31:0] seen[3];
    int n_seen = 0;
    int xc[$];
    do_reset(); imem_ack = 1; if_ready = 1;
    for (int c = 0; c < 12; c++) begin
      settle();
      n_vec++; if (imem_req !== exp_req) begin n_err++; $display("FAIL seq_req c%0d got %b exp %b", c, imem_req, exp_req); end
      n_vec++; if (if_valid !== exp_valid) begin n_err++; $display("FAIL seq_valid c%0d got %b exp %b", c, if_valid, exp_valid); end
      if (exp_valid) begin
        n_vec++; if (if_pc !== exp_pc) begin n_err++; $display("FAIL seq_pc c%0d got %h exp %h", c, if_pc, exp_pc); end
      end
      if (imem_req && n_seen < 3) begin seen[n_seen] = imem_addr; n_seen++; end
      if (if_valid && if_ready) xc.push_back(c);
      tick();
    end
    n_vec++; if (seen[0] !== 32'h3000) begin n_err++; $display("FAIL seq_addr0 got %h exp 00003000", seen[0]); end
    n_vec++; if (seen[1] !== 32'h3004) begin n_err++; $display("FAIL seq_addr1 got %h exp 00003004", seen[1]); end
    n_vec++; if (seen[2] !== 32'h3008) begin n_err++; $display("FAIL seq_addr2 got %h exp 00003008", seen[2]); end
    n_vec++; if (xc.size() != 5) begin n_err++; $display("FAIL seq_xfer_count got %0d exp 5", xc.size()); end
    for (int i = 1; i < xc.size(); i++) begin
      n_vec++; if (xc[i] - xc[i-1] != 2) begin n_err++; $display("FAIL seq_xfer_gap got %0d exp 2", xc[i] - xc[i-1]); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset(); imem_ack = 1; if_ready = 0;
    run_until_valid(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_timeout got 0 exp 1"); end
    for (int c = 0; c < 5; c++) begin
      settle();
      n_vec++; if (if_valid !== 1'b1 || imem_req !== 1'b0) begin n_err++; $display("FAIL stall_hs got v%b r%b exp v1 r0", if_valid, imem_req); end
      n_vec++; if (if_pc !== 32'h3000 || if_instr !== mem_word(32'h3000)) begin n_err++; $display("FAIL stall_hold got %h/%h exp 00003000/%h", if_pc, if_instr, mem_word(32'h3000)); end
      tick();
    end
    if_ready = 1; settle();
    n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stall_release got %b exp 1", if_valid); end
    tick(); if_ready = 0; settle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin n_err++; $display("FAIL stall_next got %b/%h exp 1/00003004", imem_req, imem_addr); end
  endtask

`ifdef FETCH_DELAY_SLOT_EN
  task automatic test_delay_slot();
    bit ok;
    do_reset(); imem_ack = 1; if_ready = 0;
    run_until_valid(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ds_timeout got 0 exp 1"); end
    if_ready = 1; settle(); tick();
    redir_valid = 1; redir_op = 2'b01; redir_pc = 32'h3000; redir_imm = 26'h000_000F;
    settle();
    n_vec++; if (imem_addr !== 32'h3004) begin n_err++; $display("FAIL ds_slot_addr got %h exp 00003004", imem_addr); end
    tick(); clear_redir(); settle();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h3004) begin n_err++; $display("FAIL ds_slot_deliver got %b/%h exp 1/00003004", if_valid, if_pc); end
    tick(); settle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h3040) begin n_err++; $display("FAIL ds_target got %b/%h exp 1/00003040", imem_req, imem_addr); end
    tick(); settle();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h3040) begin n_err++; $display("FAIL ds_target_pc got %b/%h exp 1/00003040", if_valid, if_pc); end
    tick();
  endtask
`else
  task automatic test_branch_in_out();
    bit ok;
    do_reset(); imem_ack = 1; if_ready = 0;
    run_until_valid(ok);
    if_ready = 1; settle(); tick(); if_ready = 0;
    run_until_valid(ok);
    n_vec++; if (!ok || if_pc !== 32'h3004) begin n_err++; $display("FAIL br_setup got %b/%h exp 1/00003004", ok, if_pc); end
    redir_valid = 1; redir_op = 2'b01; redir_pc = 32'h3004; redir_imm = 26'h000_0003; if_ready = 1;
    settle();
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL br_mask got %b exp 0", if_valid); end
    tick(); clear_redir(); if_ready = 0; settle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h3014) begin n_err++; $display("FAIL br_target got %b/%h exp 1/00003014", imem_req, imem_addr); end
    tick();
  endtask

  task automatic test_jump_waiting();
    do_reset(); imem_ack = 0; if_ready = 1;
    settle(); tick();
    redir_valid = 1; redir_op = 2'b10; redir_pc = 32'h3008; redir_imm = 26'h000_0C40;
    settle(); tick(); clear_redir();
    for (int c = 0; c < 2; c++) begin
      settle();
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_err++; $display("FAIL jmp_latched got %b/%h exp 1/00003000", imem_req, imem_addr); end
      tick();
    end
    imem_ack = 1; settle(); imem_rdata = 32'hDEAD_BEEF; tick();
    settle();
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL jmp_stale got %b exp 0", if_valid); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h3100) begin n_err++; $display("FAIL jmp_target got %b/%h exp 1/00003100", imem_req, imem_addr); end
    tick(); settle();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h3100 || if_instr !== mem_word(32'h3100)) begin n_err++; $display("FAIL jmp_deliver got %b/%h/%h exp 1/00003100/%h", if_valid, if_pc, if_instr, mem_word(32'h3100)); end
    tick();
  endtask

  task automatic test_jr_wrap();
    bit ok;
    do_reset(); imem_ack = 1; if_ready = 0;
    run_until_valid(ok);
    redir_valid = 1; redir_op = 2'b11; redir_ra = 32'hFFFF_FFFC;
    settle();
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL jr_mask got %b exp 0", if_valid); end
    tick(); clear_redir(); settle();
    n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL jr_addr got %h exp fffffffc", imem_addr); end
    tick(); if_ready = 1; settle();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL jr_deliver got %b/%h exp 1/fffffffc", if_valid, if_pc); end
    tick(); if_ready = 0; settle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin n_err++; $display("FAIL jr_wrap got %b/%h exp 1/00000000", imem_req, imem_addr); end
    tick();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      imem_ack = ($urandom_range(0, 9) < 6);
      if_ready = ($urandom_range(0, 9) < 7);
      clear_redir();
      if ($urandom_range(0, 99) < 15) begin
        redir_valid = 1;
        redir_op    = 2'($urandom_range(0, 3));
        redir_pc    = m_next - 32'd4;
        redir_imm   = 26'($urandom);
        redir_ra    = $urandom;
      end
      settle();
      n_vec++; if (imem_req !== exp_req) begin n_err++; $display("FAIL rnd_req c%0d got %b exp %b", c, imem_req, exp_req); end
      if (exp_req) begin
        n_vec++; if (imem_addr !== exp_addr) begin n_err++; $display("FAIL rnd_addr c%0d got %h exp %h", c, imem_addr, exp_addr); end
      end
      n_vec++; if (if_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid c%0d got %b exp %b", c, if_valid, exp_valid); end
      if (exp_valid) begin
        n_vec++; if (if_pc !== exp_pc || if_instr !== exp_instr) begin n_err++; $display("FAIL rnd_data c%0d got %h/%h exp %h/%h", c, if_pc, if_instr, exp_pc, exp_instr); end
      end
      tick();
    end
    clear_redir();
  endtask

  task automatic test_async_reset();
    do_reset(); imem_ack = 1; if_ready = 1;
    for (int c = 0; c < 5; c++) begin settle(); tick(); end
    imem_ack = 0; settle(); tick(); settle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008 || if_pc !== 32'h3004) begin n_err++; $display("FAIL ar_setup got %b/%h/%h exp 1/00003008/00003004", imem_req, imem_addr, if_pc); end
    #1 rst_n = 0;
    #1;
    n_vec++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL ar_hs got r%b v%b exp r0 v0", imem_req, if_valid); end
    n_vec++; if (imem_addr !== RST || if_pc !== RST || if_instr !== 32'd0) begin n_err++; $display("FAIL ar_regs got %h/%h/%h exp %h/%h/0", imem_addr, if_pc, if_instr, RST, RST); end
    imem_ack = 1;
    repeat (2) @(negedge clk);
    model_reset(); rst_n = 1;
    settle();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL ar_req_pre got %b exp 0", imem_req); end
    tick(); settle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== RST) begin n_err++; $display("FAIL ar_restart got %b/%h exp 1/%h", imem_req, imem_addr, RST); end
    tick();
  endtask

  initial begin
    rst_n = 0; clear_redir(); imem_ack = 0; if_ready = 0; imem_rdata = '0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
`ifdef FETCH_DELAY_SLOT_EN
    test_delay_slot();
`else
    test_branch_in_out();
    test_jump_waiting();
    test_jr_wrap();
`endif
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
